// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: mem_op codes, FSM states
// and the byte-enable width.
package dmem_pkg;

  localparam int unsigned BE_W = 4;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ0 = 2'd1,
    S_REQ1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: store byte enables and lane-aligned data over a
// two-word window, plus load byte merge and sign/zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_off,
  input  logic [31:0]       i_st_wdata,
  output logic [2*BE_W-1:0] o_be,
  output logic [63:0]       o_wdata,
  input  logic [2:0]        i_ld_op,
  input  logic [1:0]        i_ld_off,
  input  logic [31:0]       i_ld_lo,
  input  logic [23:0]       i_ld_hi,
  output logic [31:0]       o_ld_data
);

  logic [BE_W-1:0] w_mask;
  logic [31:0]     w_st_data;
  logic [31:0]     w_word;

  always_comb begin
    case (i_st_size)
      2'b00: begin
        w_mask    = 4'b0001;
        w_st_data = {24'h0, i_st_wdata[7:0]};
      end
      2'b01: begin
        w_mask    = 4'b0011;
        w_st_data = {16'h0, i_st_wdata[15:0]};
      end
      default: begin
        w_mask    = 4'b1111;
        w_st_data = i_st_wdata;
      end
    endcase
    // Upper half of the window belongs to the following word (split access).
    o_be    = {{BE_W{1'b0}}, w_mask} << i_st_off;
    o_wdata = {32'h0, w_st_data} << {i_st_off, 3'b000};
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_word = i_ld_lo;
      2'd1:    w_word = {i_ld_hi[7:0],  i_ld_lo[31:8]};
      2'd2:    w_word = {i_ld_hi[15:0], i_ld_lo[31:16]};
      default: w_word = {i_ld_hi[23:0], i_ld_lo[31:24]};
    endcase
    case (i_ld_op)
      MEM_LB:  o_ld_data = {{24{w_word[7]}},  w_word[7:0]};
      MEM_LH:  o_ld_data = {{16{w_word[15]}}, w_word[15:0]};
      MEM_LBU: o_ld_data = {24'h0, w_word[7:0]};
      MEM_LHU: o_ld_data = {16'h0, w_word[15:0]};
      MEM_LW:  o_ld_data = w_word;
      default: o_ld_data = w_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: core load/store to word bus with valid/ack handshake.
// DMEM_MISALIGN_SPLIT_EN: split word-crossing accesses instead of rejecting them.
module dmem_ctrl
  import dmem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [2:0]      mem_op,
  input  logic            mem_w,
  input  logic            mem_r,
  output logic [31:0]     rdata,
  output logic            stall,
  output logic            misalign,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_ack,
  input  logic [31:0]     bus_rdata
);

`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic            r_split;
  logic [2:0]      r_op;
  logic [1:0]      r_off;
  logic [BE_W-1:0] r_be_hi;
  logic [31:0]     r_wdata_hi;
  logic [31:0]     r_lo;

  logic            w_req;
  logic            w_misal;
  logic            w_reject;
  logic            w_split;
  logic [7:0]      w_be;
  logic [63:0]     w_wdata;
  logic [31:0]     w_ld_lo;
  logic [31:0]     w_ld_data;

  assign w_req = mem_w | mem_r;

  always_comb begin
    case (mem_op[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = addr[0];
      default: w_misal = |addr[1:0];
    endcase
  end

  // Without splitting every crossing access is also misaligned, so w_split is 0.
  assign w_reject = w_misal & ~SPLIT_EN;
  assign w_split  = (|w_be[7:4]) & ~w_reject;
  assign w_ld_lo  = (r_state == S_REQ1) ? r_lo : bus_rdata;

  dmem_lane u_lane (
    .i_st_size  (mem_op[1:0]),
    .i_st_off   (addr[1:0]),
    .i_st_wdata (wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_op    (r_op),
    .i_ld_off   (r_off),
    .i_ld_lo    (w_ld_lo),
    .i_ld_hi    (bus_rdata[23:0]),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = (r_state != S_DONE) && (w_req || (r_state != S_IDLE));
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = w_reject ? S_DONE : S_REQ0;
      S_REQ0:  if (bus_ack) w_state_nxt = r_split ? S_REQ1 : S_DONE;
      S_REQ1:  if (bus_ack) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata      <= '0;
      misalign   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      r_we       <= 1'b0;
      r_split    <= 1'b0;
      r_op       <= '0;
      r_off      <= '0;
      r_be_hi    <= '0;
      r_wdata_hi <= '0;
      r_lo       <= '0;
    end else begin
      misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we       <= mem_w;
            r_op       <= mem_op;
            r_off      <= addr[1:0];
            r_split    <= w_split;
            r_be_hi    <= w_be[7:4];
            r_wdata_hi <= w_wdata[63:32];
            if (w_reject) begin
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_w;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= w_be[3:0];
              bus_wdata <= w_wdata[31:0];
            end
          end
        end
        S_REQ0: begin
          if (bus_ack) begin
            if (r_split) begin
              r_lo      <= bus_rdata;
              bus_addr  <= bus_addr + 32'd4;
              bus_be    <= r_be_hi;
              bus_wdata <= r_wdata_hi;
            end else begin
              bus_req <= 1'b0;
              bus_we  <= 1'b0;
              if (!r_we) rdata <= w_ld_data;
            end
          end
        end
        S_REQ1: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!r_we) rdata <= w_ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the core's load/store outputs. It converts each core-side load or store into one or two word-aligned bus transactions with byte enables and a valid/ack handshake. It extracts and sign- or zero-extends load data, and holds the core with `stall` until the access completes. It turns the combinational RAM port into a multi-cycle, wait-state-tolerant memory interface.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: byte address from the ALU result.
- `wdata` in 32: store data, i.e. the rs2 value.
- `mem_op` in 3: funct3 encoding. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores use 000/001/010 as SB/SH/SW.
- `mem_w` in 1: store request.
- `mem_r` in 1: load request. `mem_w` and `mem_r` are never both high.
- `rdata` out 32: extended load result. Valid only in DONE.
- `stall` out 1: freezes pc and register write.
- `misalign` out 1: one-cycle pulse when a misaligned access is rejected.
- `bus_req` out 1: transaction valid.
- `bus_we` out 1: write transaction.
- `bus_addr` out 32: word address; bits [1:0] are always 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_ack` in 1: transaction complete. Read data is valid in the same cycle.
- `bus_rdata` in 32: read word.

## Operation
- **FSM states:** IDLE, REQ0, REQ1, DONE. REQ1 exists only with the split feature.
- **IDLE:**
  - When `mem_w|mem_r` is high, latch the access and go to REQ0.
  - `stall` is asserted combinationally in this same cycle.
- **REQ0:**
  - `bus_req` is high.
  - `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` stay stable until `bus_ack`.
  - On ack:
    - a read captures its bytes;
    - go to REQ1 if a second word is needed, otherwise go to DONE.
- **REQ1:** second word at `bus_addr`+4, with the same handshake rules as REQ0; on ack go to DONE.
- **DONE:**
  - `stall` is 0 and `rdata` is valid.
  - The core commits on this edge; the next state is IDLE unconditionally.
  - The new instruction is never accepted in DONE.
- **Byte enables, aligned access:**
  - byte: `be` = 0001 << addr[1:0];
  - half: `be` = 0011 << (addr[1]*2);
  - word: `be` = 1111.
- **Store data:** replicated or shifted into the enabled lanes. Lanes that are not enabled carry 0.
- **Load extraction:**
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- **Misaligned access:** half with addr[0]=1, or word with addr[1:0]≠0. Behaviour is set by the macro in Configuration.
- **Stall:** `stall` = (state≠DONE) && (access pending or state≠IDLE).
- **Bus acks:** an ack in IDLE or DONE is ignored.
- **Reset:** state IDLE and all outputs 0, including `rdata`. A reset during REQ0/REQ1 abandons the transaction, and `bus_req` is 0 on the next cycle. A late `bus_ack` after reset is ignored.

## Timing
- **Zero-wait bus** (ack in the first REQ cycle): aligned access has a 3-cycle latency (IDLE, REQ0, DONE) with `stall` high for 2 cycles.
- **Wait states:** each wait cycle adds one cycle of latency.
- **Registered outputs:** all bus outputs and `rdata` are registered.
- **Combinational outputs:** `stall` in IDLE only.
- **Address wrap:** a split second word at 0xFFFFFFFC+4 wraps to 0x00000000.

## Configuration
- **`DMEM_MISALIGN_SPLIT_EN` defined:**
  - A misaligned access that crosses a word boundary performs REQ0 (low word, upper lanes) then REQ1 (high word, lower lanes), and the bytes are merged before extraction.
  - Misaligned accesses within one word use a single transaction.
  - `misalign` is tied to 0.
- **Undefined:**
  - A misaligned access issues no bus transaction and goes from IDLE straight to DONE.
  - `misalign` pulses for 1 cycle coincident with DONE and `rdata` is 0.
  - `stall` is high for 1 cycle. A store writes nothing.

## Structure
- **Package `dmem_pkg`:**
  - mem_op localparams (LB..LHU);
  - FSM state encoding;
  - a `be` width constant.
- **Sub-module `dmem_lane`** (combinational):
  - store lane alignment and `be` generation;
  - load byte merge and extension;
  - instantiated once.

## Test plan
- **LW, addr 0x100:** `bus_rdata`=0xDEADBEEF with ack on the first REQ cycle. Expect `bus_be`=1111, `bus_addr`=0x100, `stall` high for 2 cycles, `rdata`=0xDEADBEEF in DONE.
- **LB at 0x103 and LBU at 0x103:** word 0x80FF_0000. Expect LB→0xFFFFFF80 and LBU→0x00000080, with `be`=1000.
- **SH, addr 0x102:** `wdata`=0x1234ABCD, ack delayed 3 cycles. Expect `bus_wdata`=0xABCD0000 and `be`=1100, held stable for 4 REQ cycles; `stall` high for 5 cycles.
- **LW at 0x0FE, split enabled:** words 0x11223344 at 0x0FC and 0x55667788 at 0x100. Expect two transactions and `rdata`=0x77881122. Same access with split disabled: `misalign` pulse, no `bus_req`, `rdata`=0.
- **Reset mid-access:** assert `rst` in REQ0, then raise a late ack. Expect `bus_req`=0 next cycle, state IDLE, no `rdata` update.
- **Wrap:** split word store at 0xFFFFFFFE. Expect second `bus_addr`=0x00000000 with `be`=0011.
